// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RV32I encoding constants for the program loader: opcode, funct3
// and funct7 values for the supported subset, the symbolic op enum used on
// the loader input, the canonical NOP word and the default address width.
package riscv_pkg;

  localparam int ADDR_W_DEF = 8;

  // addi x0,x0,0 -- substituted for any instruction that cannot be encoded
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_ANDI = 3'b111;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;

  typedef enum logic [2:0] {
    OP_LH      = 3'd0,
    OP_SH      = 3'd1,
    OP_ADD     = 3'd2,
    OP_OR      = 3'd3,
    OP_SLL     = 3'd4,
    OP_ANDI    = 3'd5,
    OP_BNE     = 3'd6,
    OP_INVALID = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } loader_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack
// Purely combinational encoder: symbolic {op, rd, rs1, rs2, imm} to a
// 32-bit RV32I word plus an error flag. Unencodable input yields the NOP.
// Ports:
//   op    in  3   symbolic operation (op_e)
//   rd    in  5   destination register
//   rs1   in  5   first source register
//   rs2   in  5   second source register
//   imm   in  13  signed immediate (byte offset for branches)
//   instr out 32  encoded word, NOP on error
//   err   out 1   encoding failed
module instr_field_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // A 13-bit value fits a signed 12-bit field when its top two bits agree.
  logic imm12_ok;
  assign imm12_ok = (imm[12] == imm[11]);

  always_comb begin
    instr = NOP_WORD;
    err   = 1'b0;
    case (op_e'(op))
      OP_LH:
        if (imm12_ok) instr = {imm[11:0], rs1, F3_LH, rd, OPC_LOAD};
        else          err   = 1'b1;
      OP_SH:
        if (imm12_ok) instr = {imm[11:5], rs2, rs1, F3_SH, imm[4:0], OPC_STORE};
        else          err   = 1'b1;
      OP_ADD:  instr = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_OP};
      OP_OR:   instr = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_OP};
      OP_SLL:  instr = {F7_BASE, rs2, rs1, F3_SLL, rd, OPC_OP};
      OP_ANDI:
        if (imm12_ok) instr = {imm[11:0], rs1, F3_ANDI, rd, OPC_OP_IMM};
        else          err   = 1'b1;
      // Branch offsets must be halfword aligned; bit 0 is never encoded.
      OP_BNE:
        if (!imm[0]) instr = {imm[12], imm[10:5], rs2, rs1, F3_BNE,
                              imm[4:1], imm[11], OPC_BRANCH};
        else         err   = 1'b1;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Program loader: accepts symbolic instructions, encodes them to RV32I words
// and streams them with sequential word addresses toward instruction-memory
// write logic. One-deep registered, backpressured output stage.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a program (only honoured while idle)
//   in_valid / in_ready   input handshake
//   in_op, in_rd, in_rs1, in_rs2, in_imm, in_last   symbolic instruction
//   out_valid / out_ready output handshake
//   out_instr, out_addr, out_err   encoded word, its address, NOP-substituted
//   done                  one-cycle pulse once the program has drained
//   err_cnt               saturating count of encode errors since start
//   wrapped               sticky: address counter wrapped since start
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [12:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              done,
  output logic [7:0]        err_cnt,
  output logic              wrapped
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  loader_state_e     state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [31:0]       enc_instr;
  logic              enc_err;
  logic              accept;
  logic              xfer;

  instr_field_pack u_pack (
    .op    (in_op),
    .rd    (in_rd),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .imm   (in_imm),
    .instr (enc_instr),
    .err   (enc_err)
  );

  // The output register may be refilled in the same cycle it empties, which
  // gives one word per cycle while the sink keeps out_ready high.
  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr_cnt  <= BASE;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      wrapped   <= 1'b0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= enc_instr;
        out_err   <= enc_err;
        out_addr  <= addr_cnt;
        addr_cnt  <= addr_cnt + ADDR_W'(1);
        if (addr_cnt == '1) wrapped <= 1'b1;
        if (enc_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE:
          if (start) begin
            state    <= ST_RUN;
            addr_cnt <= BASE;
            err_cnt  <= '0;
            wrapped  <= 1'b0;
          end
        ST_RUN:
          if (accept && in_last) state <= ST_DRAIN;
        // No new words arrive here, so the stage is empty once it is either
        // already invalid or handing its final word over this cycle.
        ST_DRAIN:
          if (!out_valid || xfer) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader
// Drives directed and randomized programs into two loader instances (default
// address width and a 2-bit address width) and compares every cycle against
// a behavioural model built from the instruction-format rules.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;
  logic        in_last;
  logic        out_ready;

  logic        in_ready,  in_ready_w2;
  logic        out_valid, out_valid_w2;
  logic [31:0] out_instr, out_instr_w2;
  logic [7:0]  out_addr;
  logic [1:0]  out_addr_w2;
  logic        out_err,   out_err_w2;
  logic        done,      done_w2;
  logic [7:0]  err_cnt,   err_cnt_w2;
  logic        wrapped,   wrapped_w2;

  instr_encoder_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
    .done(done), .err_cnt(err_cnt), .wrapped(wrapped)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready_w2),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid_w2), .out_ready(out_ready),
    .out_instr(out_instr_w2), .out_addr(out_addr_w2), .out_err(out_err_w2),
    .done(done_w2), .err_cnt(err_cnt_w2), .wrapped(wrapped_w2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [31:0] instr;
    bit        err;
    int        n;
  } exp_word_t;

  exp_word_t m_q[$];
  int        m_state;
  int        m_n;
  int        m_errs;
  bit        m_done;
  bit        m_accept;

  int check_count = 0;
  int error_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Reference encoder built from the instruction-format field positions.
  function automatic void model_encode(input bit [2:0] op, input bit [4:0] rd,
                                       input bit [4:0] rs1, input bit [4:0] rs2,
                                       input bit [12:0] imm,
                                       output bit [31:0] word, output bit err);
    int s;
    int opc;
    int f3;
    int u;
    s    = int'($signed(imm));
    u    = s & 'h1FFF;
    err  = 1'b0;
    word = 32'h0;
    opc  = 0;
    f3   = 0;
    case (op)
      3'd0: begin opc = 'h03; f3 = 1; end
      3'd1: begin opc = 'h23; f3 = 1; end
      3'd2: begin opc = 'h33; f3 = 0; end
      3'd3: begin opc = 'h33; f3 = 6; end
      3'd4: begin opc = 'h33; f3 = 1; end
      3'd5: begin opc = 'h13; f3 = 7; end
      3'd6: begin opc = 'h63; f3 = 1; end
      default: err = 1'b1;
    endcase
    if (!err) begin
      case (op)
        3'd0, 3'd5:
          if (s < -2048 || s > 2047) err = 1'b1;
          else word = opc + rd * 128 + f3 * 4096 + rs1 * 32768 + (s & 'hFFF) * 1048576;
        3'd1:
          if (s < -2048 || s > 2047) err = 1'b1;
          else word = opc + (s & 31) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576
                      + ((s >>> 5) & 127) * 33554432;
        3'd6:
          if (s % 2 != 0) err = 1'b1;
          else word = opc + ((u >> 11) & 1) * 128 + ((u >> 1) & 15) * 256 + f3 * 4096
                      + rs1 * 32768 + rs2 * 1048576 + ((u >> 5) & 63) * 33554432
                      + (((u >> 12) & 1) != 0 ? 32'h8000_0000 : 32'h0);
        default:
          word = opc + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576;
      endcase
    end
    if (err) word = 32'h0000_0013;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_state = 0;
    m_n     = 0;
    m_errs  = 0;
    m_done  = 1'b0;
  endtask

  // One clock cycle: drive inputs, check both instances mid-cycle, then
  // advance the model across the rising edge. Entered and left at posedge+1.
  task automatic applyStimulus(input bit st, input bit v, input bit [2:0] op,
                               input bit [4:0] rd, input bit [4:0] rs1,
                               input bit [4:0] rs2, input bit [12:0] imm,
                               input bit last, input bit ordy);
    bit        exp_ready;
    bit [31:0] wi;
    bit        we;
    exp_word_t w;
    start = st; in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_imm = imm; in_last = last; out_ready = ordy;
    @(negedge clk);
    exp_ready = (m_state == 1) && (m_q.size() == 0 || ordy);
    checkOutput("in_ready", in_ready, exp_ready);
    checkOutput("in_ready_w2", in_ready_w2, exp_ready);
    checkOutput("out_valid", out_valid, m_q.size() != 0);
    checkOutput("out_valid_w2", out_valid_w2, m_q.size() != 0);
    if (m_q.size() != 0) begin
      checkOutput("out_instr", out_instr, m_q[0].instr);
      checkOutput("out_err", out_err, m_q[0].err);
      checkOutput("out_addr", out_addr, m_q[0].n % 256);
      checkOutput("out_instr_w2", out_instr_w2, m_q[0].instr);
      checkOutput("out_addr_w2", out_addr_w2, m_q[0].n % 4);
    end
    checkOutput("done", done, m_done);
    checkOutput("done_w2", done_w2, m_done);
    checkOutput("err_cnt", err_cnt, m_errs);
    checkOutput("err_cnt_w2", err_cnt_w2, m_errs);
    checkOutput("wrapped", wrapped, m_n >= 256);
    checkOutput("wrapped_w2", wrapped_w2, m_n >= 4);

    m_accept = v && exp_ready;
    m_done   = 1'b0;
    if (m_q.size() != 0 && ordy) void'(m_q.pop_front());
    if (m_accept) begin
      model_encode(op, rd, rs1, rs2, imm, wi, we);
      w.instr = wi;
      w.err   = we;
      w.n     = m_n;
      m_q.push_back(w);
      m_n++;
      if (we && m_errs < 255) m_errs++;
    end
    case (m_state)
      0: if (st) begin m_state = 1; m_n = 0; m_errs = 0; end
      1: if (m_accept && last) m_state = 2;
      2: if (m_q.size() == 0) begin m_state = 0; m_done = 1'b1; end
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (m_state != 0 && g < 20) begin
      idle_cycle();
      g++;
    end
    if (m_state != 0) checkOutput("drain_timeout", 1, 0);
    idle_cycle();
    idle_cycle();
  endtask

  task automatic random_program(input int beats);
    int        guard;
    bit [2:0]  op;
    bit [12:0] imm;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    guard = 0;
    while (m_n < beats && guard < 20 * beats) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: imm = 13'd2047;
        1: imm = 13'd2048;
        2: imm = 13'h1800;
        3: imm = 13'h17FF;
        default: imm = 13'($urandom_range(0, 8191));
      endcase
      if (op == 3'd6 && $urandom_range(0, 1) == 0) imm[0] = 1'b0;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0, op,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), imm, m_n == beats - 1,
                    $urandom_range(0, 3) != 0);
      guard++;
    end
    if (m_n < beats) checkOutput("program_timeout", 1, 0);
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_out_instr", out_instr, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    idle_cycle();

    // add x3,x1,x2 then lh x5,8(x2) as the last beat
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 3'd2, 5'd3, 5'd1, 5'd2, 13'd0, 0, 1);
    checkOutput("add_word", out_instr, 32'h002081B3);
    checkOutput("add_addr", out_addr, 0);
    applyStimulus(0, 1, 3'd0, 5'd5, 5'd2, 5'd0, 13'd8, 1, 1);
    checkOutput("lh_word", out_instr, 32'h00811283);
    checkOutput("lh_addr", out_addr, 1);
    idle_cycle();
    checkOutput("done_pulse", done, 1);
    drain();

    // bne x1,x2,-4 and sh x6,-2(x7)
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 3'd6, 5'd0, 5'd1, 5'd2, 13'h1FFC, 0, 1);
    checkOutput("bne_word", out_instr, 32'hFE209EE3);
    checkOutput("bne_err", out_err, 0);
    applyStimulus(0, 1, 3'd1, 5'd0, 5'd7, 5'd6, 13'h1FFE, 1, 1);
    checkOutput("sh_word", out_instr, 32'hFE639F23);
    checkOutput("sh_err", out_err, 0);
    drain();

    // three encode errors
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 3'd5, 5'd1, 5'd1, 5'd0, 13'd2048, 0, 1);
    checkOutput("andi_big_word", out_instr, 32'h00000013);
    checkOutput("andi_big_err", out_err, 1);
    applyStimulus(0, 1, 3'd7, 5'd1, 5'd1, 5'd1, 13'd0, 0, 1);
    checkOutput("op7_err", out_err, 1);
    applyStimulus(0, 1, 3'd6, 5'd0, 5'd1, 5'd2, 13'd3, 1, 1);
    checkOutput("bne_odd_word", out_instr, 32'h00000013);
    checkOutput("bne_odd_err", out_err, 1);
    drain();
    checkOutput("err_cnt_three", err_cnt, 3);

    // backpressure: sink stalls for five cycles with input pending
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 1, 3'd3, 5'(i + 1), 5'd4, 5'd5, 13'd0, 0, 0);
    checkOutput("stall_in_ready", in_ready, 0);
    checkOutput("stall_addr", out_addr, 0);
    applyStimulus(0, 1, 3'd4, 5'd9, 5'd10, 5'd11, 13'd0, 1, 1);
    checkOutput("stall_next_addr", out_addr, 1);
    drain();

    // reset while a word is pending
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 3'd5, 5'd4, 5'd4, 5'd0, 13'd5, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_out_instr", out_instr, 0);
    checkOutput("arst_in_ready", in_ready, 0);
    checkOutput("arst_done", done, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 3'd2, 5'd1, 5'd1, 5'd1, 13'd0, 0, 1);

    // randomized programs; the long one wraps both address counters
    random_program(300);
    for (int p = 0; p < 4; p++) random_program(20 + p * 7);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
